bowling_roll_generator: RTL and testbench

- Stimulus-side counterpart to the score board: produces legal bowling rolls as one-cycle `update` pulses with pin count `N`.
- Its outputs wire directly to the score board's `update`/`N` inputs.
- Pin counts come from a seeded 16-bit LFSR scaled to the pins still standing, so every roll is rule-legal.
- Tracks frame, roll-in-frame and 10th-frame bonus rules; stops after the final roll of the game.

---
 rtl/bowling_roll_generator.sv | 147 ++++++++++++++
 tb/tb_bowling_roll_generator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bowling_roll_generator.sv
// bowling_roll_generator
// Produces legal bowling rolls as one-cycle update pulses carrying pin count N,
// intended to drive a score board's update/N inputs directly. Pin counts come
// from a seeded 16-bit Galois LFSR scaled to the pins still standing, so every
// roll is rule-legal. Frame, roll-in-frame and 10th-frame bonus rolls are
// tracked, and the generator stops after the final roll of the game.
//
// Optional feature: define BOWLING_ROLL_FORCE_EN to add force_en/force_pins,
// which override the random pin count (clamped to the pins still standing).
// The LFSR keeps advancing while forced.

module bowling_roll_generator #(
    parameter int          ROLL_GAP     = 4,        // idle cycles between rolls, 1..255
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1  // used when seed input is zero
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] seed,
`ifdef BOWLING_ROLL_FORCE_EN
    input  logic        force_en,
    input  logic [3:0]  force_pins,
`endif
    output logic        update,
    output logic [3:0]  N,
    output logic [3:0]  frame,
    output logic [1:0]  roll_in_frame,
    output logic [4:0]  roll_count,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, GAP, ROLL, DONE} state_t;

    state_t      state;
    logic [7:0]  gap_cnt;
    logic [3:0]  remaining;      // pins standing for the next roll
    logic [15:0] lfsr;
    logic        tenth_strike;   // first roll of frame 10 was a strike

    logic [3:0]  rem_plus1;
    logic [11:0] roll_prod;
    logic [3:0]  roll_pins;
    logic [3:0]  next_remaining;
    logic [15:0] lfsr_next;

    // Roll value, next LFSR step and pins left after the current roll.
    always_comb begin
        rem_plus1 = remaining + 4'd1;
        // Scaling an 8-bit random by (remaining+1)/256 can never exceed remaining.
        roll_prod = {4'd0, lfsr[7:0]} * {8'd0, rem_plus1};
        roll_pins = 4'(roll_prod >> 8);
`ifdef BOWLING_ROLL_FORCE_EN
        if (force_en) begin
            roll_pins = (force_pins > remaining) ? remaining : force_pins;
        end
`endif
        lfsr_next      = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        // Knocking down everything standing (strike or spare) re-racks all ten.
        next_remaining = (N == remaining) ? 4'd10 : remaining - N;
    end

    // Game sequencer: start, roll spacing, frame bookkeeping and game end.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would make results order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            update        <= 1'b0;
            N             <= 4'd0;
            frame         <= 4'd1;
            roll_in_frame <= 2'd1;
            roll_count    <= 5'd0;
            game_over     <= 1'b0;
            remaining     <= 4'd10;
            lfsr          <= DEFAULT_SEED;
            gap_cnt       <= 8'd0;
            tenth_strike  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr          <= (seed == 16'd0) ? DEFAULT_SEED : seed;
                        frame         <= 4'd1;
                        roll_in_frame <= 2'd1;
                        roll_count    <= 5'd0;
                        remaining     <= 4'd10;
                        tenth_strike  <= 1'b0;
                        game_over     <= 1'b0;
                        gap_cnt       <= 8'(ROLL_GAP);
                        state         <= GAP;
                    end
                end

                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        // Outputs are registered, so the roll is latched on entry to ROLL.
                        state  <= ROLL;
                        update <= 1'b1;
                        N      <= roll_pins;
                    end
                end

                ROLL: begin
                    update     <= 1'b0;
                    lfsr       <= lfsr_next;
                    roll_count <= roll_count + 5'd1;
                    gap_cnt    <= 8'(ROLL_GAP);
                    state      <= GAP;
                    if (frame != 4'd10) begin
                        if (roll_in_frame == 2'd1 && N != 4'd10) begin
                            remaining     <= next_remaining;
                            roll_in_frame <= 2'd2;
                        end else begin
                            frame         <= frame + 4'd1;
                            roll_in_frame <= 2'd1;
                            remaining     <= 4'd10;
                        end
                    end else begin
                        case (roll_in_frame)
                            2'd1: begin
                                tenth_strike  <= (N == 4'd10);
                                remaining     <= next_remaining;
                                roll_in_frame <= 2'd2;
                            end
                            2'd2: begin
                                // Bonus roll after a strike or a spare in frame 10.
                                if (tenth_strike || N == remaining) begin
                                    remaining     <= next_remaining;
                                    roll_in_frame <= 2'd3;
                                end else begin
                                    state     <= DONE;
                                    game_over <= 1'b1;
                                end
                            end
                            default: begin
                                state     <= DONE;
                                game_over <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bowling_roll_generator.sv
// tb_bowling_roll_generator
// Scoreboard bench: a behavioural game model pushes the expected roll list
// when a game is started; each update pulse pops and compares one entry.
// Forced-pin scenarios are built only when BOWLING_ROLL_FORCE_EN is defined.

module tb_bowling_roll_generator;

    localparam int ROLL_GAP = 4;

    typedef struct {
        int n;
        int frame;
        int rif;
        int cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] seed;
    logic        update;
    logic [3:0]  n;
    logic [3:0]  frame;
    logic [1:0]  roll_in_frame;
    logic [4:0]  roll_count;
    logic        game_over;
`ifdef BOWLING_ROLL_FORCE_EN
    logic        force_en;
    logic [3:0]  force_pins;
`endif

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    bit   fen[0:21];
    int   fpin[0:21];

    bowling_roll_generator #(.ROLL_GAP(ROLL_GAP), .DEFAULT_SEED(16'hACE1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .seed         (seed),
`ifdef BOWLING_ROLL_FORCE_EN
        .force_en     (force_en),
        .force_pins   (force_pins),
`endif
        .update       (update),
        .N            (n),
        .frame        (frame),
        .roll_in_frame(roll_in_frame),
        .roll_count   (roll_count),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_force();
        for (int i = 0; i < 22; i++) begin
            fen[i]  = 1'b0;
            fpin[i] = 0;
        end
    endtask

    task automatic apply_force(input int idx);
`ifdef BOWLING_ROLL_FORCE_EN
        force_en   = fen[idx];
        force_pins = 4'(fpin[idx]);
`else
        if (idx < 0) $display("apply_force: bad index %0d", idx);
`endif
    endtask

    // Plays a whole game by the bowling rules and queues every expected roll.
    task automatic build_expected(input logic [15:0] sd, output int nrolls);
        logic [15:0] l;
        int rem, fr, rif, pins, cnt;
        bit ts, done;
        l = (sd == 16'd0) ? 16'hACE1 : sd;
        fr = 1; rif = 1; rem = 10; ts = 0; done = 0; cnt = 0;
        while (!done) begin
            if (fen[cnt]) pins = (fpin[cnt] > rem) ? rem : fpin[cnt];
            else          pins = (int'(l[7:0]) * (rem + 1)) / 256;
            exp_q.push_back('{pins, fr, rif, cnt});
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            cnt++;
            if (fr < 10) begin
                if (rif == 1 && pins != 10) begin rem = 10 - pins; rif = 2; end
                else begin fr++; rif = 1; rem = 10; end
            end else if (rif == 1) begin
                ts  = (pins == 10);
                rem = ts ? 10 : 10 - pins;
                rif = 2;
            end else if (rif == 2) begin
                if (ts) begin rem = (pins == 10) ? 10 : 10 - pins; rif = 3; end
                else if (pins == rem) begin rem = 10; rif = 3; end
                else done = 1;
            end else begin
                done = 1;
            end
        end
        nrolls = cnt;
    endtask

    // Starts a game, compares every update against the scoreboard, checks spacing.
    task automatic run_game(input logic [15:0] sd, input bit poke_start);
        int   nrolls, cyc, last_upd, seen;
        bit   fin;
        exp_t e;
        exp_q.delete();
        build_expected(sd, nrolls);
        @(negedge clk);
        start = 1'b1;
        seed  = sd;
        apply_force(0);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; last_upd = 0; seen = 0; fin = 0;
        while (!fin && cyc < 400) begin
            if (update) begin
                if (exp_q.size() == 0) begin
                    check("extra_update", seen, nrolls - 1);
                end else begin
                    e = exp_q.pop_front();
                    check("roll_pins", int'(n), e.n);
                    check("roll_frame", int'(frame), e.frame);
                    check("roll_in_frame", int'(roll_in_frame), e.rif);
                    check("roll_count_at_update", int'(roll_count), e.cnt);
                end
                check("update_spacing", cyc - last_upd, ROLL_GAP + 1);
                last_upd = cyc;
                seen++;
            end
            if (game_over) fin = 1;
            apply_force(seen);
            if (poke_start) start = (cyc == 7 || cyc == 10);
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) check("game_timeout", 0, 1);
        check("roll_count_end", int'(roll_count), nrolls);
        check("rolls_outstanding", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("done_holds_game_over", int'(game_over), 1);
        check("done_no_update", int'(update), 0);
    endtask

    // Aborts a game in a GAP cycle of frame 5 and checks the reset values.
    task automatic reset_mid_game(input logic [15:0] sd);
        int  cyc, upd;
        bit  hit;
        @(negedge clk);
        start = 1'b1;
        seed  = sd;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (cyc = 0; cyc < 300 && !hit; cyc++) begin
            if (frame == 4'd5 && !update) hit = 1;
            else @(negedge clk);
        end
        check("reach_frame5", int'(hit), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_update", int'(update), 0);
        check("abort_frame", int'(frame), 1);
        check("abort_roll_in_frame", int'(roll_in_frame), 1);
        check("abort_roll_count", int'(roll_count), 0);
        check("abort_game_over", int'(game_over), 0);
        upd = 0;
        repeat (12) begin
            @(negedge clk);
            if (update) upd++;
        end
        check("idle_after_abort", upd, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        seed  = 16'd0;
        clear_force();
        apply_force(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_update", int'(update), 0);
        check("reset_N", int'(n), 0);
        check("reset_frame", int'(frame), 1);
        check("reset_roll_in_frame", int'(roll_in_frame), 1);
        check("reset_roll_count", int'(roll_count), 0);
        check("reset_game_over", int'(game_over), 0);
        reset = 1'b0;

        // Default seed, seed zero (must match it), and start pokes in GAP/ROLL.
        run_game(16'hACE1, 1'b0);
        run_game(16'h0000, 1'b0);
        run_game(16'h1234, 1'b1);
        for (int i = 0; i < 30; i++) begin
            run_game(16'($urandom_range(1, 65535)), 1'b0);
        end

        // Abort mid-game, then the same seed must replay from roll 1.
        reset_mid_game(16'h5A5A);
        run_game(16'h5A5A, 1'b0);

`ifdef BOWLING_ROLL_FORCE_EN
        // Perfect game.
        for (int i = 0; i < 22; i++) begin fen[i] = 1'b1; fpin[i] = 10; end
        run_game(16'h0001, 1'b0);
        check("perfect_roll_count", int'(roll_count), 12);

        // All gutter balls: no bonus roll.
        for (int i = 0; i < 22; i++) begin fen[i] = 1'b1; fpin[i] = 0; end
        run_game(16'h0002, 1'b0);
        check("gutter_roll_count", int'(roll_count), 20);

        // 7/3 spare every frame; forcing 10 on the bonus proves a full rack.
        for (int i = 0; i < 22; i++) begin fen[i] = 1'b1; fpin[i] = (i % 2 == 0) ? 7 : 3; end
        fpin[20] = 10;
        run_game(16'h0003, 1'b0);
        check("spare_roll_count", int'(roll_count), 21);
        check("spare_bonus_pins", int'(n), 10);

        // Force 15 with 3 pins standing clamps to 3; rest of game random.
        clear_force();
        fen[0] = 1'b1; fpin[0] = 7;
        fen[1] = 1'b1; fpin[1] = 15;
        run_game(16'hBEEF, 1'b0);
        clear_force();
        apply_force(0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
